// File: rtl/reg_if_id_elastic.sv
// IF/ID pipeline register with valid/ready flow control.
// A main slot drives the decode-side outputs and a skid slot absorbs the one
// extra fetch that can arrive before the registered o_ready drops. Flush turns
// the stage into a NOP bubble. A saturating counter records back-pressure cycles.
module reg_if_id_elastic #(
    parameter int unsigned      NBITS    = 32,
    parameter logic [NBITS-1:0] NOP      = '0,
    parameter int unsigned      CNT_BITS = 16
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_flush,
    input  logic                i_valid,
    output logic                o_ready,
    input  logic [NBITS-1:0]    i_pc,
    input  logic [NBITS-1:0]    i_instruction,
    output logic                o_valid,
    input  logic                i_ready,
    output logic [NBITS-1:0]    o_pc,
    output logic [NBITS-1:0]    o_instruction,
    output logic [CNT_BITS-1:0] o_stall_cnt
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_HALF  = 2'b01,
        ST_FULL  = 2'b10
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [NBITS-1:0] main_pc_p1;
    logic [NBITS-1:0] main_instr_p1;
    logic [NBITS-1:0] skid_pc_p1;
    logic [NBITS-1:0] skid_instr_p1;

    logic [NBITS-1:0] main_pc_d;
    logic [NBITS-1:0] main_instr_d;
    logic [NBITS-1:0] skid_pc_d;
    logic [NBITS-1:0] skid_instr_d;

    logic [CNT_BITS-1:0] stall_cnt_p1;

    logic push;
    logic pop;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_BITS-1:0] sat_inc(input logic [CNT_BITS-1:0] x);
        if (&x) begin
            return x;
        end
        return x + CNT_BITS'(1);
    endfunction

    // o_ready comes from registered state only, so i_ready never reaches it
    // combinationally; the skid slot covers the one-cycle lag.
    assign push = i_valid & o_ready;
    assign pop  = o_valid & i_ready;

    // State register.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; flush empties the stage regardless of push/pop.
    always_comb begin
        state_d = state_q;
        if (i_flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (push) state_d = ST_HALF;
                end
                ST_HALF: begin
                    if (push && !pop)      state_d = ST_FULL;
                    else if (!push && pop) state_d = ST_EMPTY;
                end
                ST_FULL: begin
                    if (pop) state_d = ST_HALF;
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    // Slot contents for the next cycle; an emptied slot holds PC 0 and NOP so
    // decode sees a clean bubble even when it ignores o_valid.
    always_comb begin
        main_pc_d    = main_pc_p1;
        main_instr_d = main_instr_p1;
        skid_pc_d    = skid_pc_p1;
        skid_instr_d = skid_instr_p1;
        if (i_flush) begin
            main_pc_d    = '0;
            main_instr_d = NOP;
            skid_pc_d    = '0;
            skid_instr_d = NOP;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (push) begin
                        main_pc_d    = i_pc;
                        main_instr_d = i_instruction;
                    end
                end
                ST_HALF: begin
                    if (push && pop) begin
                        main_pc_d    = i_pc;
                        main_instr_d = i_instruction;
                    end else if (push) begin
                        skid_pc_d    = i_pc;
                        skid_instr_d = i_instruction;
                    end else if (pop) begin
                        main_pc_d    = '0;
                        main_instr_d = NOP;
                    end
                end
                ST_FULL: begin
                    if (pop) begin
                        main_pc_d    = skid_pc_p1;
                        main_instr_d = skid_instr_p1;
                        skid_pc_d    = '0;
                        skid_instr_d = NOP;
                    end
                end
                default: begin
                    main_pc_d    = '0;
                    main_instr_d = NOP;
                    skid_pc_d    = '0;
                    skid_instr_d = NOP;
                end
            endcase
        end
    end

    // ---- stage p1: slot registers ----
    // Slot registers; reset leaves both slots holding the bubble value.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            main_pc_p1    <= '0;
            main_instr_p1 <= NOP;
            skid_pc_p1    <= '0;
            skid_instr_p1 <= NOP;
        end else begin
            main_pc_p1    <= main_pc_d;
            main_instr_p1 <= main_instr_d;
            skid_pc_p1    <= skid_pc_d;
            skid_instr_p1 <= skid_instr_d;
        end
    end

    // Stall counter: counts edges where a valid output is refused; flush does not clear it.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            stall_cnt_p1 <= '0;
        end else if (o_valid && !i_ready) begin
            stall_cnt_p1 <= sat_inc(stall_cnt_p1);
        end
    end

    // Output decode from registered state.
    always_comb begin
        o_valid       = (state_q != ST_EMPTY);
        o_ready       = (state_q != ST_FULL);
        o_pc          = main_pc_p1;
        o_instruction = main_instr_p1;
        o_stall_cnt   = stall_cnt_p1;
    end

endmodule

// File: tb/tb_reg_if_id_elastic.sv
// Bench for reg_if_id_elastic: directed scenarios with literal expectations,
// then randomized traffic, all checked every cycle against a queue-based model.
module tb_reg_if_id_elastic;

    localparam int unsigned NBITS    = 32;
    localparam int unsigned CNT_BITS = 4;
    localparam logic [31:0] NOP_VAL  = 32'h0000_0020;
    localparam logic [3:0]  CNT_MAX  = 4'hF;

    logic                i_clk;
    logic                i_rst;
    logic                i_flush;
    logic                i_valid;
    logic                o_ready;
    logic [NBITS-1:0]    i_pc;
    logic [NBITS-1:0]    i_instruction;
    logic                o_valid;
    logic                i_ready;
    logic [NBITS-1:0]    o_pc;
    logic [NBITS-1:0]    o_instruction;
    logic [CNT_BITS-1:0] o_stall_cnt;

    reg_if_id_elastic #(
        .NBITS    (NBITS),
        .NOP      (NOP_VAL),
        .CNT_BITS (CNT_BITS)
    ) dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_flush       (i_flush),
        .i_valid       (i_valid),
        .o_ready       (o_ready),
        .i_pc          (i_pc),
        .i_instruction (i_instruction),
        .o_valid       (o_valid),
        .i_ready       (i_ready),
        .o_pc          (o_pc),
        .o_instruction (o_instruction),
        .o_stall_cnt   (o_stall_cnt)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
    } ent_t;

    ent_t        mq[$];
    logic [3:0]  m_cnt = 4'd0;
    int          n_tests = 0;
    int          n_fail  = 0;
    bit          chk_en  = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    // Reference model: a FIFO of at most two entries; the head is the output.
    initial begin
        forever begin
            bit m_push;
            bit m_pop;
            @(posedge i_clk);
            if (!i_rst) begin
                mq.delete();
                m_cnt = 4'd0;
            end else begin
                if (mq.size() != 0 && !i_ready && m_cnt != CNT_MAX) m_cnt = m_cnt + 4'd1;
                if (i_flush) begin
                    mq.delete();
                end else begin
                    m_pop  = (mq.size() != 0) && i_ready;
                    m_push = i_valid && (mq.size() < 2);
                    if (m_pop) void'(mq.pop_front());
                    if (m_push) mq.push_back('{pc: i_pc, ins: i_instruction});
                end
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge i_clk);
            if (chk_en) begin
                logic        e_valid;
                logic [31:0] e_pc;
                logic [31:0] e_ins;
                e_valid = (mq.size() != 0);
                e_pc    = e_valid ? mq[0].pc  : 32'h0;
                e_ins   = e_valid ? mq[0].ins : NOP_VAL;
                check("m_valid", 64'(o_valid), 64'(e_valid));
                check("m_ready", 64'(o_ready), 64'(mq.size() < 2));
                check("m_pc",    64'(o_pc), 64'(e_pc));
                check("m_instr", 64'(o_instruction), 64'(e_ins));
                check("m_cnt",   64'(o_stall_cnt), 64'(m_cnt));
            end
        end
    end

    logic [31:0] prog [3];

    initial begin
        prog[0] = 32'h2008_0005;
        prog[1] = 32'h2009_0003;
        prog[2] = 32'h0109_5020;

        // Reset held for 3 edges with a fetch offered.
        i_rst = 1'b0; i_flush = 1'b0; i_valid = 1'b1; i_ready = 1'b1;
        i_pc = 32'h100; i_instruction = 32'hABCD_0001;
        repeat (3) step();
        chk_en = 1'b1;
        check("rst_valid", 64'(o_valid), 64'd0);
        check("rst_instr", 64'(o_instruction), 64'h20);
        check("rst_pc",    64'(o_pc), 64'd0);
        check("rst_ready", 64'(o_ready), 64'd1);
        check("rst_cnt",   64'(o_stall_cnt), 64'd0);
        i_rst = 1'b1; i_valid = 1'b0;
        step();

        // Streaming with no back-pressure.
        for (int i = 0; i < 3; i++) begin
            i_valid = 1'b1; i_pc = 32'(i * 4); i_instruction = prog[i];
            step();
            check("str_valid", 64'(o_valid), 64'd1);
            check("str_pc",    64'(o_pc), 64'(i * 4));
            check("str_instr", 64'(o_instruction), 64'(prog[i]));
        end
        // Drain to empty.
        i_valid = 1'b0;
        step();
        check("drain_valid", 64'(o_valid), 64'd0);
        check("drain_pc",    64'(o_pc), 64'd0);
        check("drain_instr", 64'(o_instruction), 64'h20);

        // Back-pressure: HALF with 0x4, then 3 refused cycles with 0x8 offered.
        i_valid = 1'b1; i_pc = 32'h4; i_instruction = 32'h1111_0004;
        step();
        i_ready = 1'b0; i_pc = 32'h8; i_instruction = 32'h1111_0008;
        step();
        check("bp_ready", 64'(o_ready), 64'd0);
        check("bp_pc1",   64'(o_pc), 64'h4);
        step();
        step();
        check("bp_pc3",   64'(o_pc), 64'h4);
        check("bp_cnt",   64'(o_stall_cnt), 64'd3);
        check("bp_mcnt",  64'(m_cnt), 64'd3);
        i_valid = 1'b0; i_ready = 1'b1;
        step();
        check("bp_next_pc",    64'(o_pc), 64'h8);
        check("bp_next_instr", 64'(o_instruction), 64'h1111_0008);
        step();
        check("bp_empty", 64'(o_valid), 64'd0);

        // Flush while FULL, with a fetch of 0x10 offered.
        i_valid = 1'b1; i_pc = 32'h20; i_instruction = 32'h2222_0020;
        step();
        i_ready = 1'b0; i_pc = 32'h24; i_instruction = 32'h2222_0024;
        step();
        check("fl_full", 64'(o_ready), 64'd0);
        i_flush = 1'b1; i_ready = 1'b1; i_pc = 32'h10; i_instruction = 32'h3333_0010;
        step();
        check("fl_valid", 64'(o_valid), 64'd0);
        check("fl_instr", 64'(o_instruction), 64'h20);
        check("fl_ready", 64'(o_ready), 64'd1);
        check("fl_cnt",   64'(o_stall_cnt), 64'd4);
        i_flush = 1'b0; i_valid = 1'b0;
        step();
        check("fl_gone", 64'(o_valid), 64'd0);

        // Flush from HALF with an accepted push: the push is dropped.
        i_valid = 1'b1; i_ready = 1'b0; i_pc = 32'h30; i_instruction = 32'h4444_0030;
        step();
        i_flush = 1'b1; i_ready = 1'b1; i_pc = 32'h10; i_instruction = 32'h3333_0010;
        step();
        i_flush = 1'b0; i_valid = 1'b0;
        step();
        check("flh_gone", 64'(o_valid), 64'd0);
        check("flh_pc",   64'(o_pc), 64'd0);

        // Saturation: 20 cycles with i_ready low.
        i_valid = 1'b1; i_ready = 1'b0; i_pc = 32'h40; i_instruction = 32'h5555_0040;
        repeat (20) step();
        check("sat_cnt", 64'(o_stall_cnt), 64'd15);
        step();
        check("sat_hold", 64'(o_stall_cnt), 64'd15);
        i_rst = 1'b0;
        step();
        check("sat_rst_cnt",   64'(o_stall_cnt), 64'd0);
        check("sat_rst_valid", 64'(o_valid), 64'd0);
        check("sat_rst_ready", 64'(o_ready), 64'd1);
        i_rst = 1'b1; i_valid = 1'b0; i_ready = 1'b1;
        step();

        // Randomized traffic with phases of varying back-pressure.
        for (int c = 0; c < 3000; c++) begin
            int rdy_pct;
            rdy_pct = ((c / 500) % 3 == 0) ? 8 : (((c / 500) % 3 == 1) ? 5 : 2);
            i_valid       = ($urandom_range(0, 9) < 7);
            i_ready       = ($urandom_range(0, 9) < rdy_pct);
            i_flush       = ($urandom_range(0, 19) == 0);
            i_rst         = ($urandom_range(0, 99) != 0);
            i_pc          = $urandom & 32'hFFFF_FFFC;
            i_instruction = $urandom;
            step();
        end
        i_rst = 1'b1; i_flush = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
        repeat (3) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
